// File: rtl/acc_stream_buffer.sv
// acc_stream_buffer: captures a non-backpressured DMA word stream in a FIFO and replays it as a framed valid/ready stream
//   wb_clk_i, wb_rst_i (async, active-high)
//   in_valid/in_data              DMA word strobe and data
//   cfg_start/cfg_len             start a frame of cfg_len words (ignored if 0 or while streaming)
//   sm_tvalid/sm_tdata/sm_tready/sm_tlast   output stream to the accelerator
//   buf_afull                     occupancy >= AFULL_LVL
//   buf_overflow                  sticky: a word was dropped because the FIFO was full
//   frame_done                    one-cycle pulse after the frame's last handshake
//   busy                          a frame is being streamed
module acc_stream_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = 12,
    parameter int LEN_WIDTH  = 10
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  cfg_start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    output logic                  sm_tvalid,
    output logic [DATA_WIDTH-1:0] sm_tdata,
    input  logic                  sm_tready,
    output logic                  sm_tlast,
    output logic                  buf_afull,
    output logic                  buf_overflow,
    output logic                  frame_done,
    output logic                  busy
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, STREAM} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count, count_nxt;
    logic [LEN_WIDTH-1:0]  len_r, sent;
    logic                  full, pop, wr;
    // a pop in the same cycle frees the slot, so a write into a full FIFO is still taken
    always_comb begin
        full      = count == (AW+1)'(DEPTH);
        pop       = sm_tvalid & sm_tready;
        wr        = in_valid & (~full | pop);
        count_nxt = count + (AW+1)'(wr) - (AW+1)'(pop);
    end
    assign sm_tvalid = (state == STREAM) & (count != '0);
    assign sm_tdata  = mem[rd_ptr];
    assign sm_tlast  = sm_tvalid & (sent == len_r - LEN_WIDTH'(1));
    assign busy      = state == STREAM;
    // storage is cleared on reset so sm_tdata reads 0 out of reset
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr) begin
            mem[wr_ptr] <= in_data;
        end
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            len_r        <= '0;
            sent         <= '0;
            buf_afull    <= 1'b0;
            buf_overflow <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count      <= count_nxt;
            buf_afull  <= count_nxt >= (AW+1)'(AFULL_LVL);
            frame_done <= pop & sm_tlast;
            if (state == IDLE && cfg_start && cfg_len != '0) begin
                state        <= STREAM;
                len_r        <= cfg_len;
                sent         <= '0;
                buf_overflow <= 1'b0;
            end else if (pop) begin
                sent <= sent + LEN_WIDTH'(1);
                if (sm_tlast) state <= IDLE;
            end
            // a drop in the start cycle must still be reported, so set wins over clear
            if (in_valid && !wr) buf_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_acc_stream_buffer.sv
// tb_acc_stream_buffer: randomized and directed checks of acc_stream_buffer against a queue-based frame model
module tb_acc_stream_buffer;
    logic        wb_clk_i, wb_rst_i;
    logic        in_valid, cfg_start, sm_tready;
    logic [31:0] in_data;
    logic [9:0]  cfg_len;
    logic        sm_tvalid, sm_tlast, buf_afull, buf_overflow, frame_done, busy;
    logic [31:0] sm_tdata;
    int          n_checks = 0, n_fail = 0;
    logic [31:0] q[$];
    bit          m_str, m_ovf, m_done;
    int          m_len, m_sent;
    bit          tg;

    acc_stream_buffer dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .in_valid(in_valid), .in_data(in_data),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata),
        .sm_tready(sm_tready), .sm_tlast(sm_tlast), .buf_afull(buf_afull),
        .buf_overflow(buf_overflow), .frame_done(frame_done), .busy(busy)
    );

    initial begin
        wb_clk_i = 0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        bit v, last, pop, acc;
        #1;
        v    = m_str && q.size() > 0;
        last = v && (m_sent == m_len - 1);
        check("tvalid", sm_tvalid, v);
        if (v) check("tdata", sm_tdata, q[0]);
        check("tlast", sm_tlast, last);
        check("busy", busy, m_str);
        check("afull", buf_afull, q.size() >= 12);
        check("overflow", buf_overflow, m_ovf);
        check("frame_done", frame_done, m_done);
        @(posedge wb_clk_i);
        pop    = v && sm_tready;
        acc    = in_valid && (q.size() < 16 || pop);
        m_done = pop && last;
        if (pop) begin
            void'(q.pop_front());
            m_sent++;
        end
        if (acc) q.push_back(in_data);
        if (!m_str && cfg_start && cfg_len != 0) begin
            m_str = 1; m_len = cfg_len; m_sent = 0; m_ovf = 0;
        end else if (pop && last) m_str = 0;
        if (in_valid && !acc) m_ovf = 1;
        #1;
    endtask

    task automatic drive(bit iv, logic [31:0] d, bit st, int len, bit tr);
        in_valid  = iv;
        in_data   = d;
        cfg_start = st;
        cfg_len   = 10'(len);
        sm_tready = tr;
        step();
    endtask

    task automatic do_reset();
        in_valid = 0; cfg_start = 0; sm_tready = 0; in_data = 0; cfg_len = 0;
        wb_rst_i = 1;
        #1;
        check("rst_tvalid", sm_tvalid, 0);
        check("rst_tdata", sm_tdata, 0);
        check("rst_tlast", sm_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_afull", buf_afull, 0);
        check("rst_overflow", buf_overflow, 0);
        check("rst_frame_done", frame_done, 0);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 0;
        q.delete();
        m_str = 0; m_ovf = 0; m_done = 0; m_len = 0; m_sent = 0;
    endtask

    task automatic basic_frame();
        drive(0, 0, 1, 4, 1);
        for (int i = 0; i < 4; i++) drive(1, 32'hA0 + i, 0, 0, 1);
        repeat (4) drive(0, 0, 0, 0, 1);
    endtask

    initial begin
        do_reset();
        basic_frame();
        // backpressure: tready alternates every cycle
        drive(0, 0, 1, 8, 1);
        tg = 0;
        for (int i = 0; i < 8; i++) begin
            tg = ~tg;
            drive(1, $urandom, 0, 0, tg);
        end
        repeat (16) begin
            tg = ~tg;
            drive(0, 0, 0, 0, tg);
        end
        // overflow: 17 writes into an idle FIFO
        for (int i = 0; i < 17; i++) drive(1, 32'h100 + i, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        // full FIFO with simultaneous write and pop
        drive(0, 0, 1, 17, 0);
        drive(1, 32'hBEEF, 0, 0, 1);
        repeat (20) drive(0, 0, 0, 0, 1);
        // prefill in IDLE, zero-length start ignored, then a 3-word frame
        for (int i = 0; i < 3; i++) drive(1, 32'hC0 + i, 0, 0, 1);
        drive(0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 1, 3, 1);
        repeat (5) drive(0, 0, 0, 0, 1);
        repeat (3000)
            drive($urandom_range(0, 1), $urandom, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 20), $urandom_range(0, 3) != 0);
        // reset mid-frame after two of five words are delivered
        do_reset();
        drive(1, 32'hD0, 1, 5, 1);
        for (int i = 1; i < 5 && m_sent < 2; i++) drive(1, 32'hD0 + i, 0, 0, 1);
        do_reset();
        basic_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
